// File: rtl/trace_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : trace_buffer_if
//  Description : Capture, control and read-back signal bundle for the
//                instruction-trace buffer. The host side (core/bench) uses
//                the master modport; the buffer itself uses slave.
//  Revision    : 1.0 - initial release
// ============================================================================
interface trace_buffer_if #(
    parameter int PC_W  = 32,
    parameter int INS_W = 32,
    parameter int DEPTH = 16
);
    localparam int C_CNT_W = $clog2(DEPTH) + 1;

    // capture side
    logic [PC_W-1:0]    pc;
    logic [INS_W-1:0]   ins;
    logic               fetch;
    // control
    logic               arm;
    logic               trig_en;
    logic [PC_W-1:0]    trig_pc;
    // read-back side
    logic               rd_en;
    logic [PC_W-1:0]    rd_pc;
    logic [INS_W-1:0]   rd_ins;
    logic               rd_valid;
    // status
    logic [C_CNT_W-1:0] count;
    logic [1:0]         state;
    logic               overflow;

    modport master (
        output pc, ins, fetch, arm, trig_en, trig_pc, rd_en,
        input  rd_pc, rd_ins, rd_valid, count, state, overflow
    );

    modport slave (
        input  pc, ins, fetch, arm, trig_en, trig_pc, rd_en,
        output rd_pc, rd_ins, rd_valid, count, state, overflow
    );
endinterface
`default_nettype wire

// File: rtl/trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : trace_buffer
//  Description : Instruction-trace capture buffer. Records {pc, ins} of every
//                fetch while capturing, stop-when-full (MODE 0) or circular
//                overwrite (MODE 1), with an optional PC-match trigger that
//                stops capture POST_DEPTH fetches later. Pop-style read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module trace_buffer #(
    parameter int PC_W       = 32,
    parameter int INS_W      = 32,
    parameter int DEPTH      = 16,
    parameter int MODE       = 0,
    parameter int POST_DEPTH = 4
) (
    input  wire logic        clk,
    input  wire logic        PcReSet_n,
    trace_buffer_if.slave    bus
);
    localparam int C_PTR_W = $clog2(DEPTH);
    localparam int C_CNT_W = C_PTR_W + 1;
    localparam int C_ENT_W = PC_W + INS_W;
    localparam logic [C_CNT_W-1:0] C_FULL     = C_CNT_W'(DEPTH);
    // POST_DEPTH < DEPTH, so it always fits in a pointer-wide counter
    localparam logic [C_PTR_W-1:0] C_POST_CNT = C_PTR_W'(POST_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_POST    = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t               state_q,    state_d;
    logic [C_PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [C_PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [C_CNT_W-1:0]   count_q,    count_d;
    logic                 overflow_q, overflow_d;
    logic [C_PTR_W-1:0]   post_cnt_q, post_cnt_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [PC_W-1:0]      rd_pc_q,    rd_pc_d;
    logic [INS_W-1:0]     rd_ins_q,   rd_ins_d;

    logic [C_ENT_W-1:0]   mem_q [DEPTH];
    logic                 w_mem_we;

    logic w_full;
    logic w_empty;
    logic w_wr_req;
    logic w_rd;
    logic w_trig;
    logic w_inc;

    assign w_full   = (count_q == C_FULL);
    assign w_empty  = (count_q == '0);
    assign w_wr_req = ((state_q == ST_CAPTURE) || (state_q == ST_POST)) && bus.fetch;
    assign w_rd     = bus.rd_en && !w_empty;
    assign w_trig   = (state_q == ST_CAPTURE) && bus.trig_en && bus.fetch
                      && (bus.pc == bus.trig_pc);
    // A write grows the buffer unless it lands on a full buffer without a
    // same-cycle pop; a full+pop write simply reuses the slot being freed.
    assign w_inc    = w_wr_req && (!w_full || w_rd);

    // Next-state for pointers, occupancy, read port and capture FSM
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        post_cnt_d = post_cnt_q;
        rd_valid_d = 1'b0;
        rd_pc_d    = rd_pc_q;
        rd_ins_d   = rd_ins_q;
        w_mem_we   = 1'b0;

        if (bus.arm) begin
            // restart wins over everything else on this edge, including
            // the fetch and any read request
            state_d    = ST_CAPTURE;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            post_cnt_d = '0;
        end else begin
            // read port: data is taken before this edge's write lands
            if (w_rd) begin
                rd_valid_d = 1'b1;
                rd_pc_d    = mem_q[rd_ptr_q][C_ENT_W-1:INS_W];
                rd_ins_d   = mem_q[rd_ptr_q][INS_W-1:0];
            end

            if (w_wr_req) begin
                if (!w_full || w_rd) begin
                    w_mem_we = 1'b1;
                    wr_ptr_d = wr_ptr_q + C_PTR_W'(1);
                end else begin
                    overflow_d = 1'b1;
                    if (MODE == 1) begin
                        // overwrite oldest: both pointers step together
                        w_mem_we = 1'b1;
                        wr_ptr_d = wr_ptr_q + C_PTR_W'(1);
                    end
                end
            end

            if (w_rd || (w_wr_req && w_full && !w_rd && (MODE == 1))) begin
                rd_ptr_d = rd_ptr_q + C_PTR_W'(1);
            end

            count_d = count_q + C_CNT_W'(w_inc) - C_CNT_W'(w_rd);

            case (state_q)
                ST_CAPTURE: begin
                    if (w_trig) begin
                        if (POST_DEPTH == 0) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d    = ST_POST;
                            post_cnt_d = C_POST_CNT;
                        end
                    end
                end
                ST_POST: begin
                    if (bus.fetch) begin
                        post_cnt_d = post_cnt_q - C_PTR_W'(1);
                        if (post_cnt_q == C_PTR_W'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Control and read-port registers
    always_ff @(posedge clk or negedge PcReSet_n) begin
        if (!PcReSet_n) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            post_cnt_q <= '0;
            rd_valid_q <= 1'b0;
            rd_pc_q    <= '0;
            rd_ins_q   <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            post_cnt_q <= post_cnt_d;
            rd_valid_q <= rd_valid_d;
            rd_pc_q    <= rd_pc_d;
            rd_ins_q   <= rd_ins_d;
        end
    end

    // Trace storage; deliberately not reset
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem_q[wr_ptr_q] <= {bus.pc, bus.ins};
        end
    end

    assign bus.rd_pc    = rd_pc_q;
    assign bus.rd_ins   = rd_ins_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.count    = count_q;
    assign bus.state    = state_q;
    assign bus.overflow = overflow_q;

endmodule
`default_nettype wire
